gemm_result_drain: RTL and testbench
====================================

GEMM_RESULT_DRAIN -- requirements
Module: gemm_result_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, bit width of one result element.
REQ-002 SHALL have parameter MATRIX_WIDTH, default 4, result columns.
REQ-003 SHALL have parameter MATRIX_HEIGHT, default 4, result rows.
REQ-004 SHALL have port iclk  input  1  the single clock; all logic on posedge.
REQ-005 SHALL have port irst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port idone  input  1  GEMM completion flag; level, may stay high for many cycles.
REQ-007 SHALL have port iresult_matrix  input  [DATA_WIDTH] x [MATRIX_HEIGHT][MATRIX_WIDTH]  GEMM result; valid while idone is high.
REQ-008 SHALL have port iready  input  1  downstream sink accepts an element.
REQ-009 SHALL have port ovalid  output  1  odata/orow/ocol/olast are valid.
REQ-010 SHALL have port odata  output  DATA_WIDTH  current element.
REQ-011 SHALL have port orow  output  $clog2(MATRIX_HEIGHT) (min 1)  row index of odata.
REQ-012 SHALL have port ocol  output  $clog2(MATRIX_WIDTH) (min 1)  column index of odata.
REQ-013 SHALL have port olast  output  1  high with the final element (H-1, W-1).
REQ-014 SHALL have port obusy  output  1  high while a captured matrix is not fully drained.
REQ-015 SHALL have port ooverrun  output  1  sticky: a result was dropped.

Function
REQ-016 SHALL use FSM states IDLE and STREAM.
REQ-017 SHALL detect a capture event as a rising edge of idone (idone=1, registered idone_q=0); a held-high idone SHALL NOT cause recapture.
REQ-018 In IDLE, a capture event SHALL copy iresult_matrix into an internal H x W buffer, clear row/col to 0, and enter STREAM; ovalid SHALL be 1 on the next cycle (latency 1).
REQ-019 In STREAM, ovalid SHALL be 1 and odata SHALL equal buffer[orow][ocol].
REQ-020 A transfer SHALL occur only when ovalid && iready; then the index advances row-major (ocol+1; at ocol=W-1 wrap to 0 and orow+1).
REQ-021 While ovalid && !iready, odata, orow, ocol, olast SHALL hold stable.
REQ-022 olast SHALL equal 1 exactly when orow=H-1 and ocol=W-1 and ovalid=1.
REQ-023 On the transfer of the last element with no simultaneous capture event, the FSM SHALL return to IDLE; ovalid=0 the following cycle.
REQ-024 A capture event in the same cycle as the last-element transfer SHALL be accepted: buffer reloaded, indices reset to 0, FSM stays STREAM, no overrun.
REQ-025 A capture event in STREAM at any other cycle SHALL be dropped, buffer unchanged, and ooverrun set to 1 until reset.
REQ-026 obusy SHALL equal (state == STREAM).
REQ-027 Data SHALL pass unmodified (no sign change, truncation, or scaling).

Reset
REQ-028 When irst=1 at a posedge: state=IDLE, row=col=0, idone_q=0, ovalid=0, olast=0, obusy=0, ooverrun=0, odata=0; buffer contents need not be cleared.
REQ-029 Reset mid-STREAM SHALL abort the drain; no further elements output until a new capture event after irst deasserts.
REQ-030 idone already high when irst deasserts SHALL count as a rising edge (idone_q reset to 0).

Structure
REQ-031 The state enum typedef (IDLE, STREAM) SHALL live in shared package gemm_pkg alongside the default DATA_WIDTH/MATRIX_WIDTH/MATRIX_HEIGHT constants.
REQ-032 No sub-module is required; buffer, index counters and FSM SHALL be implemented inline in one module.

Verification
REQ-033 Capture 4x4 matrix r[i][j]=16*i+j, iready=1 constant -> 16 consecutive transfers, odata 0..15... in row-major order (values 0,1,2,3,16,17,...,51), olast only on element 51, ovalid low the cycle after.
REQ-034 Same matrix, iready toggling 1/0 each cycle -> odata stable during stalls, 16 transfers in 31-32 cycles, order unchanged.
REQ-035 idone held high 40 cycles -> exactly one 16-element drain, ooverrun=0.
REQ-036 Second idone rising edge at element 5 -> ooverrun=1, remaining elements from first matrix, no second drain.
REQ-037 Second rising edge coincident with last-element transfer -> second matrix streams starting next cycle, ooverrun=0, no ovalid gap.
REQ-038 irst=1 at element 7 -> ovalid=0, obusy=0 next cycle; subsequent capture restarts at (0,0).

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and default geometry for the GEMM result drain.
package gemm_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 64;
    localparam int unsigned DEFAULT_MATRIX_WIDTH  = 4;
    localparam int unsigned DEFAULT_MATRIX_HEIGHT = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gemm_result_drain.sv
// Captures a finished GEMM result matrix and streams it out row-major over a
// valid/ready handshake, one element per accepted transfer.
module gemm_result_drain
    import gemm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned MATRIX_WIDTH  = DEFAULT_MATRIX_WIDTH,
    parameter int unsigned MATRIX_HEIGHT = DEFAULT_MATRIX_HEIGHT
) (
    input  logic                                                       iclk,
    input  logic                                                       irst,
    input  logic                                                       idone,
    input  logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] iresult_matrix,
    input  logic                                                       iready,
    output logic                                                       ovalid,
    output logic [DATA_WIDTH-1:0]                                      odata,
    output logic [idx_width(MATRIX_HEIGHT)-1:0]                        orow,
    output logic [idx_width(MATRIX_WIDTH)-1:0]                         ocol,
    output logic                                                       olast,
    output logic                                                       obusy,
    output logic                                                       ooverrun
);

    localparam int unsigned RW = idx_width(MATRIX_HEIGHT);
    localparam int unsigned CW = idx_width(MATRIX_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);

    drain_state_t r_state;
    drain_state_t w_state_d;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row_d;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col_d;
    logic          r_idone_q;
    logic          r_overrun;
    logic          w_overrun_d;
    logic          w_capture;
    logic          w_fire;
    logic          w_at_last;
    logic          w_load;
    logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] r_buf;

    assign w_capture = idone & ~r_idone_q;
    assign w_fire    = (r_state == STREAM) & iready;
    assign w_at_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

    always_comb begin
        w_state_d   = r_state;
        w_row_d     = r_row;
        w_col_d     = r_col;
        w_overrun_d = r_overrun;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_load    = 1'b1;
                    w_row_d   = '0;
                    w_col_d   = '0;
                    w_state_d = STREAM;
                end
            end
            STREAM: begin
                if (w_fire && w_at_last) begin
                    // A new result arriving exactly as the old one finishes is chained.
                    w_row_d = '0;
                    w_col_d = '0;
                    if (w_capture) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_d = IDLE;
                    end
                end else begin
                    if (w_capture) begin
                        w_overrun_d = 1'b1;
                    end
                    if (w_fire) begin
                        if (r_col == COL_LAST) begin
                            w_col_d = '0;
                            w_row_d = r_row + RW'(1);
                        end else begin
                            w_col_d = r_col + CW'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_idone_q <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_row     <= w_row_d;
            r_col     <= w_col_d;
            r_idone_q <= idone;
            r_overrun <= w_overrun_d;
        end
    end

    // Buffer is never cleared; it is only read while streaming.
    always_ff @(posedge iclk) begin
        if (w_load && !irst) begin
            r_buf <= iresult_matrix;
        end
    end

    assign ovalid   = (r_state == STREAM);
    assign obusy    = (r_state == STREAM);
    assign odata    = ovalid ? r_buf[r_row][r_col] : '0;
    assign orow     = r_row;
    assign ocol     = r_col;
    assign olast    = ovalid & w_at_last;
    assign ooverrun = r_overrun;

endmodule

// File: tb/tb_gemm_result_drain.sv
// Directed bench for gemm_result_drain: drains, stalls, held done, overrun,
// chained capture and mid-drain reset on a 4x4 matrix of 64-bit elements.
module tb_gemm_result_drain;
    import gemm_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned MW = 4;
    localparam int unsigned MH = 4;

    logic                             iclk = 1'b0;
    logic                             irst;
    logic                             idone;
    logic                             iready;
    logic [MH-1:0][MW-1:0][DW-1:0]    mat;
    logic                             ovalid;
    logic [DW-1:0]                    odata;
    logic [1:0]                       orow;
    logic [1:0]                       ocol;
    logic                             olast;
    logic                             obusy;
    logic                             ooverrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] got_data [64];
    logic [1:0]    got_row  [64];
    logic [1:0]    got_col  [64];
    logic          got_last [64];
    int            n_got;
    int            first_c;
    int            last_c;
    int            unstable;
    bit            timed_out;

    always #5 iclk = ~iclk;

    gemm_result_drain #(
        .DATA_WIDTH    (DW),
        .MATRIX_WIDTH  (MW),
        .MATRIX_HEIGHT (MH)
    ) dut (
        .iclk           (iclk),
        .irst           (irst),
        .idone          (idone),
        .iresult_matrix (mat),
        .iready         (iready),
        .ovalid         (ovalid),
        .odata          (odata),
        .orow           (orow),
        .ocol           (ocol),
        .olast          (olast),
        .obusy          (obusy),
        .ooverrun       (ooverrun)
    );

    // Element k (row-major) of a matrix built by set_matrix(base).
    function automatic logic [DW-1:0] val(input logic [DW-1:0] base, input int k);
        return base + DW'(16 * (k / 4) + (k % 4));
    endfunction

    task automatic set_matrix(input logic [DW-1:0] base);
        for (int i = 0; i < int'(MH); i++)
            for (int j = 0; j < int'(MW); j++)
                mat[i][j] = base + DW'(16 * i + j);
    endtask

    // Runs the sink side for up to max_cycles negedges and records every transfer.
    // ev_kind 1: pulse idone with a new matrix at transfer ev_at; 2: assert irst there.
    task automatic watch(input int max_cycles, input bit toggle, input bit hold_idone,
                         input int ev_kind, input int ev_at, input logic [DW-1:0] ev_base);
        logic          stalled;
        logic          pulse;
        logic [DW-1:0] p_data;
        logic [1:0]    p_row;
        logic [1:0]    p_col;
        logic          p_last;
        n_got = 0; first_c = -1; last_c = -1; unstable = 0; timed_out = 1'b1;
        stalled = 1'b0; pulse = 1'b0;
        p_data = '0; p_row = '0; p_col = '0; p_last = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge iclk);
            if (c == 0 && !hold_idone) idone = 1'b0;
            if (pulse) begin
                idone = 1'b0;
                pulse = 1'b0;
            end
            if (!ovalid) begin
                if (n_got > 0) begin
                    timed_out = 1'b0;
                    break;
                end
                continue;
            end
            if (first_c < 0) first_c = c;
            if (stalled && (odata !== p_data || orow !== p_row || ocol !== p_col ||
                            olast !== p_last)) unstable++;
            p_data = odata; p_row = orow; p_col = ocol; p_last = olast;
            iready  = toggle ? (c % 2 == 0) : 1'b1;
            stalled = !iready;
            if (iready) begin
                if (ev_kind == 2 && n_got == ev_at) begin
                    irst = 1'b1;
                end else begin
                    if (ev_kind == 1 && n_got == ev_at) begin
                        set_matrix(ev_base);
                        idone = 1'b1;
                        pulse = 1'b1;
                    end
                    got_data[n_got] = odata;
                    got_row[n_got]  = orow;
                    got_col[n_got]  = ocol;
                    got_last[n_got] = olast;
                    n_got++;
                    last_c = c;
                end
            end
        end
    endtask

    task automatic test_reset;
        irst = 1'b1; idone = 1'b0; iready = 1'b0; mat = '0;
        repeat (3) @(negedge iclk);
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
        n_checks++; if (obusy !== 1'b0) begin n_fail++; $display("FAIL reset_obusy: got %b expected 0", obusy); end
        n_checks++; if (olast !== 1'b0) begin n_fail++; $display("FAIL reset_olast: got %b expected 0", olast); end
        n_checks++; if (ooverrun !== 1'b0) begin n_fail++; $display("FAIL reset_ooverrun: got %b expected 0", ooverrun); end
        n_checks++; if (odata !== '0) begin n_fail++; $display("FAIL reset_odata: got %0h expected 0", odata); end
        n_checks++; if (orow !== 2'd0 || ocol !== 2'd0) begin n_fail++; $display("FAIL reset_index: got %0d,%0d expected 0,0", orow, ocol); end
        irst = 1'b0;
        repeat (2) @(negedge iclk);
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL idle_no_done: got ovalid %b expected 0", ovalid); end
    endtask

    task automatic test_basic;
        idone = 1'b0;
        @(negedge iclk);
        set_matrix('0);
        idone = 1'b1;
        watch(40, 1'b0, 1'b0, 0, 0, '0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got timeout expected drain end"); end
        n_checks++; if (first_c !== 0) begin n_fail++; $display("FAIL basic_latency: got %0d expected 0", first_c); end
        n_checks++; if (n_got !== 16) begin n_fail++; $display("FAIL basic_count: got %0d expected 16", n_got); end
        n_checks++; if (last_c !== 15) begin n_fail++; $display("FAIL basic_back_to_back: got last at %0d expected 15", last_c); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (got_data[k] !== val('0, k)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h expected %0h", k, got_data[k], val('0, k)); end
            n_checks++; if (got_row[k] !== 2'(k / 4) || got_col[k] !== 2'(k % 4)) begin n_fail++; $display("FAIL basic_index[%0d]: got %0d,%0d expected %0d,%0d", k, got_row[k], got_col[k], k / 4, k % 4); end
            n_checks++; if (got_last[k] !== (k == 15)) begin n_fail++; $display("FAIL basic_olast[%0d]: got %b expected %b", k, got_last[k], k == 15); end
        end
        n_checks++; if (ovalid !== 1'b0 || obusy !== 1'b0) begin n_fail++; $display("FAIL basic_after: got ovalid %b obusy %b expected 0 0", ovalid, obusy); end
        n_checks++; if (ooverrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b expected 0", ooverrun); end
    endtask

    task automatic test_stall;
        idone = 1'b0;
        @(negedge iclk);
        set_matrix('0);
        idone = 1'b1;
        watch(80, 1'b1, 1'b0, 0, 0, '0);
        n_checks++; if (n_got !== 16 || timed_out) begin n_fail++; $display("FAIL stall_count: got %0d timeout %b expected 16 0", n_got, timed_out); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", unstable); end
        n_checks++; if (last_c - first_c + 1 !== 31) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 31", last_c - first_c + 1); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (got_data[k] !== val('0, k)) begin n_fail++; $display("FAIL stall_data[%0d]: got %0h expected %0h", k, got_data[k], val('0, k)); end
            n_checks++; if (got_last[k] !== (k == 15)) begin n_fail++; $display("FAIL stall_olast[%0d]: got %b expected %b", k, got_last[k], k == 15); end
        end
    endtask

    task automatic test_held_done;
        idone = 1'b0;
        @(negedge iclk);
        set_matrix(64'd5);
        idone = 1'b1;
        watch(40, 1'b0, 1'b1, 0, 0, '0);
        n_checks++; if (n_got !== 16 || timed_out) begin n_fail++; $display("FAIL held_count: got %0d timeout %b expected 16 0", n_got, timed_out); end
        n_checks++; if (got_data[15] !== val(64'd5, 15)) begin n_fail++; $display("FAIL held_last_data: got %0h expected %0h", got_data[15], val(64'd5, 15)); end
        for (int c = 0; c < 25; c++) begin
            @(negedge iclk);
            n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL held_recapture[%0d]: got ovalid %b expected 0", c, ovalid); end
        end
        idone = 1'b0;
        n_checks++; if (ooverrun !== 1'b0) begin n_fail++; $display("FAIL held_overrun: got %b expected 0", ooverrun); end
    endtask

    task automatic test_back_to_back;
        idone = 1'b0;
        @(negedge iclk);
        set_matrix('0);
        idone = 1'b1;
        watch(80, 1'b0, 1'b0, 1, 15, 64'h8000_0000_0000_0100);
        n_checks++; if (n_got !== 32 || timed_out) begin n_fail++; $display("FAIL chain_count: got %0d timeout %b expected 32 0", n_got, timed_out); end
        n_checks++; if (last_c - first_c !== 31) begin n_fail++; $display("FAIL chain_gap: got span %0d expected 31", last_c - first_c); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (got_data[k] !== val('0, k)) begin n_fail++; $display("FAIL chain_first[%0d]: got %0h expected %0h", k, got_data[k], val('0, k)); end
            n_checks++; if (got_data[16 + k] !== val(64'h8000_0000_0000_0100, k)) begin n_fail++; $display("FAIL chain_second[%0d]: got %0h expected %0h", k, got_data[16 + k], val(64'h8000_0000_0000_0100, k)); end
            n_checks++; if (got_last[16 + k] !== (k == 15)) begin n_fail++; $display("FAIL chain_olast[%0d]: got %b expected %b", k, got_last[16 + k], k == 15); end
        end
        n_checks++; if (got_row[16] !== 2'd0 || got_col[16] !== 2'd0) begin n_fail++; $display("FAIL chain_restart_index: got %0d,%0d expected 0,0", got_row[16], got_col[16]); end
        n_checks++; if (ooverrun !== 1'b0) begin n_fail++; $display("FAIL chain_overrun: got %b expected 0", ooverrun); end
    endtask

    task automatic test_overrun;
        idone = 1'b0;
        @(negedge iclk);
        set_matrix('0);
        idone = 1'b1;
        watch(60, 1'b0, 1'b0, 1, 5, 64'd1000);
        n_checks++; if (n_got !== 16 || timed_out) begin n_fail++; $display("FAIL overrun_count: got %0d timeout %b expected 16 0", n_got, timed_out); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (got_data[k] !== val('0, k)) begin n_fail++; $display("FAIL overrun_data[%0d]: got %0h expected %0h", k, got_data[k], val('0, k)); end
        end
        n_checks++; if (ooverrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", ooverrun); end
        for (int c = 0; c < 5; c++) begin
            @(negedge iclk);
            n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL overrun_second_drain[%0d]: got ovalid %b expected 0", c, ovalid); end
        end
        n_checks++; if (ooverrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", ooverrun); end
    endtask

    task automatic test_reset_mid;
        idone = 1'b0;
        @(negedge iclk);
        set_matrix('0);
        idone = 1'b1;
        watch(60, 1'b0, 1'b0, 2, 7, '0);
        n_checks++; if (n_got !== 7 || timed_out) begin n_fail++; $display("FAIL rstmid_count: got %0d timeout %b expected 7 0", n_got, timed_out); end
        n_checks++; if (ovalid !== 1'b0 || obusy !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: got ovalid %b obusy %b expected 0 0", ovalid, obusy); end
        n_checks++; if (ooverrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun_clear: got %b expected 0", ooverrun); end
        n_checks++; if (odata !== '0 || olast !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got %0h %b expected 0 0", odata, olast); end
        // idone rises while still in reset, so its release must read as an edge.
        set_matrix(64'd200);
        idone = 1'b1;
        @(negedge iclk);
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_held: got ovalid %b expected 0", ovalid); end
        irst = 1'b0;
        watch(40, 1'b0, 1'b0, 0, 0, '0);
        n_checks++; if (n_got !== 16 || timed_out || first_c !== 0) begin n_fail++; $display("FAIL rstmid_restart: got %0d first %0d expected 16 0", n_got, first_c); end
        n_checks++; if (got_row[0] !== 2'd0 || got_col[0] !== 2'd0) begin n_fail++; $display("FAIL rstmid_origin: got %0d,%0d expected 0,0", got_row[0], got_col[0]); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (got_data[k] !== val(64'd200, k)) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %0h expected %0h", k, got_data[k], val(64'd200, k)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_held_done();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
